dup_filter_ctrl: RTL

- Sequencer for the duplicate-symbol filter in the NB-LDPC check-node path.
- Takes a sorted stream of (Q, LLR) candidates for one message vector and issues them to the filter one at a time.
- Owns the filter's thermometer occupancy mask (ID) and counts kept symbols.
- Stops at NM kept symbols or at end of stream, then signals done.

---
 rtl/nbldpc_filter_pkg.sv | 17 +
 rtl/filter_id_reg.sv | 34 +++
 rtl/dup_filter_ctrl.sv | 117 +++++++++++
 3 files changed

// File: rtl/nbldpc_filter_pkg.sv
// Shared widths and the controller state encoding for the NB-LDPC
// duplicate-symbol filter path.
package nbldpc_filter_pkg;

    localparam int COUNTER_WIDTH = 4;
    localparam int DEPTH         = 2**(COUNTER_WIDTH+1) - 1;
    localparam int Q_WIDTH       = 6;
    localparam int LLR_WIDTH     = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCEPT = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/filter_id_reg.sv
// Thermometer occupancy mask for the filter's marker slots plus the
// kept-symbol count; clear wins over increment, increment saturates at NM.
module filter_id_reg
    import nbldpc_filter_pkg::*;
#(
    parameter int COUNTER_WIDTH = nbldpc_filter_pkg::COUNTER_WIDTH,
    parameter int DEPTH         = 2**(COUNTER_WIDTH+1) - 1,
    parameter int NM            = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     inc,
    output logic [DEPTH:0]           id,
    output logic [COUNTER_WIDTH:0]   cnt
);

    localparam int CW = COUNTER_WIDTH + 1;

    // NOTE: flops use <= so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id  <= '0;
            cnt <= '0;
        end else if (clr) begin
            id  <= '0;
            cnt <= '0;
        end else if (inc && (int'(cnt) < NM)) begin
            id  <= {id[DEPTH-1:0], 1'b1};
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/dup_filter_ctrl.sv
// Issues sorted (Q, LLR) candidates one at a time to the duplicate filter,
// waits FLT_LAT cycles for its verdict and publishes kept symbols.
module dup_filter_ctrl
    import nbldpc_filter_pkg::*;
#(
    parameter int COUNTER_WIDTH = nbldpc_filter_pkg::COUNTER_WIDTH,
    parameter int DEPTH         = 2**(COUNTER_WIDTH+1) - 1,
    parameter int Q_WIDTH       = nbldpc_filter_pkg::Q_WIDTH,
    parameter int LLR_WIDTH     = nbldpc_filter_pkg::LLR_WIDTH,
    parameter int NM            = 16,
    parameter int FLT_LAT       = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [Q_WIDTH:0]       in_q,
    input  logic [LLR_WIDTH:0]     in_llr,
    input  logic                   in_last,
    output logic                   flt_valid,
    output logic [Q_WIDTH:0]       flt_q,
    output logic [LLR_WIDTH:0]     flt_llr,
    output logic [DEPTH:0]         flt_id,
    input  logic                   flt_save,
    output logic                   out_valid,
    output logic [Q_WIDTH:0]       out_q,
    output logic [LLR_WIDTH:0]     out_llr,
    output logic [COUNTER_WIDTH:0] out_idx,
    output logic [COUNTER_WIDTH:0] kept_cnt,
    output logic                   done
);

    localparam int LAT_W = $clog2(FLT_LAT + 1);

    state_t             state, state_nxt;
    logic [LAT_W-1:0]   lat_cnt;
    logic               cand_last;
    logic               take;
    logic               verdict;
    logic               keep;

    assign in_ready = (state == ACCEPT);
    assign done     = (state == DONE);

    // start aborts everything, so it gates both the handshake and the verdict.
    assign take    = in_ready && in_valid && !start;
    assign verdict = (state == WAIT) && (lat_cnt == '0);
    assign keep    = verdict && flt_save && !start;

    // NOTE: defaults first so every path assigns state_nxt (no latch).
    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = ACCEPT;
        end else begin
            case (state)
                ACCEPT:  if (in_valid) state_nxt = WAIT;
                WAIT:    if (verdict) begin
                             if ((flt_save && (int'(kept_cnt) + 1 == NM)) || cand_last)
                                 state_nxt = DONE;
                             else
                                 state_nxt = ACCEPT;
                         end
                default: state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            lat_cnt   <= '0;
            cand_last <= 1'b0;
            flt_valid <= 1'b0;
            flt_q     <= '0;
            flt_llr   <= '0;
            out_valid <= 1'b0;
            out_q     <= '0;
            out_llr   <= '0;
            out_idx   <= '0;
        end else begin
            state     <= state_nxt;
            flt_valid <= take;
            out_valid <= keep;
            if (take) begin
                cand_last <= in_last;
                flt_q     <= in_q;
                flt_llr   <= in_llr;
                lat_cnt   <= LAT_W'(FLT_LAT);
            end else if ((state == WAIT) && (lat_cnt != '0)) begin
                lat_cnt <= lat_cnt - LAT_W'(1);
            end
            if (keep) begin
                out_q   <= flt_q;
                out_llr <= flt_llr;
                out_idx <= kept_cnt;
            end
        end
    end

    // Mask moves one edge after the verdict, so it is stable while the
    // filter compares and writes its marker.
    filter_id_reg #(
        .COUNTER_WIDTH (COUNTER_WIDTH),
        .DEPTH         (DEPTH),
        .NM            (NM)
    ) u_id_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start),
        .inc   (keep),
        .id    (flt_id),
        .cnt   (kept_cnt)
    );

endmodule
